// File: rtl/uart_spi_bridge.sv
// UART-to-SPI byte bridge: buffers received bytes in a small FIFO, frames each one as a
// single chip-selected SPI transfer, and hands the returned byte to the UART transmitter.
module uart_spi_bridge #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic [DATA_W-1:0] spi_tx_data,
  output logic              spi_cs_bar,
  output logic              spi_start,
  input  logic [DATA_W-1:0] spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStart, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CntW-1:0]   tcnt_q, tcnt_d;

  logic [DATA_W-1:0] spi_tx_data_q, spi_tx_data_d;
  logic              spi_cs_bar_q, spi_cs_bar_d;
  logic              spi_start_q, spi_start_d;
  logic [DATA_W-1:0] uart_tx_data_q, uart_tx_data_d;
  logic              uart_tx_start_q, uart_tx_start_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;

  logic push, pop;

  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign push = uart_rx_valid && (count_q < (ADDR_W + 1)'(FIFO_DEPTH));
  assign pop  = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    state_d         = state_q;
    tcnt_d          = tcnt_q;
    spi_tx_data_d   = spi_tx_data_q;
    spi_cs_bar_d    = spi_cs_bar_q;
    spi_start_d     = 1'b0;
    uart_tx_data_d  = uart_tx_data_q;
    uart_tx_start_d = 1'b0;
    overflow_d      = overflow_q | (uart_rx_valid & ~push);
    timeout_d       = timeout_q;

    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          spi_tx_data_d = mem_q[rd_ptr_q];
          spi_cs_bar_d  = 1'b0;
          state_d       = StSetup;
        end
      end
      StSetup: begin
        spi_start_d = 1'b1;
        state_d     = StStart;
      end
      StStart: begin
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (spi_rx_valid) begin
          uart_tx_data_d = spi_rx_data;
          spi_cs_bar_d   = 1'b1;
          state_d        = StResp;
        end else begin
          tcnt_d = tcnt_q + CntW'(1);
          // Abandon the transfer after TIMEOUT cycles in WAIT; no response goes to the UART.
          if (tcnt_d == CntW'(TIMEOUT)) begin
            spi_cs_bar_d = 1'b1;
            timeout_d    = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      StResp: begin
        if (uart_tx_ready) begin
          uart_tx_start_d = 1'b1;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      tcnt_q          <= '0;
      spi_tx_data_q   <= '0;
      spi_cs_bar_q    <= 1'b1;
      spi_start_q     <= 1'b0;
      uart_tx_data_q  <= '0;
      uart_tx_start_q <= 1'b0;
      overflow_q      <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      tcnt_q          <= tcnt_d;
      spi_tx_data_q   <= spi_tx_data_d;
      spi_cs_bar_q    <= spi_cs_bar_d;
      spi_start_q     <= spi_start_d;
      uart_tx_data_q  <= uart_tx_data_d;
      uart_tx_start_q <= uart_tx_start_d;
      overflow_q      <= overflow_d;
      timeout_q       <= timeout_d;
    end
  end

  // Storage needs no reset: only entries behind a valid pointer pair are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= uart_rx_data;
    end
  end

  assign spi_tx_data   = spi_tx_data_q;
  assign spi_cs_bar    = spi_cs_bar_q;
  assign spi_start     = spi_start_q;
  assign uart_tx_data  = uart_tx_data_q;
  assign uart_tx_start = uart_tx_start_q;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Self-checking bench for uart_spi_bridge: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_uart_spi_bridge;

  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AW     = 2;
  localparam int unsigned TO_CYC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] uart_rx_data;
  logic          uart_rx_valid;
  logic [DW-1:0] spi_tx_data;
  logic          spi_cs_bar;
  logic          spi_start;
  logic [DW-1:0] spi_rx_data;
  logic          spi_rx_valid;
  logic [DW-1:0] uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_ready;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          timeout;

  uart_spi_bridge #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW),
    .TIMEOUT   (TO_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_cs_bar   (spi_cs_bar),
    .spi_start    (spi_start),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .uart_tx_data (uart_tx_data),
    .uart_tx_start(uart_tx_start),
    .uart_tx_ready(uart_tx_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a byte queue plus the age of the one outstanding transfer.
  logic [DW-1:0] q[$];
  bit            act, answered, chk_en, m_full;
  int            age;
  logic          e_cs, e_start, e_utxs, e_ovf, e_to;
  logic [DW-1:0] e_txd, e_utxd;
  logic [AW:0]   e_cnt;

  initial chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      act = 0; answered = 0; age = 0;
      e_cs = 1; e_start = 0; e_txd = '0; e_utxd = '0; e_utxs = 0;
      e_ovf = 0; e_to = 0; e_cnt = '0;
      chk_en = 1'b1;
    end else begin
      m_full  = (q.size() == DEPTH);
      e_start = 0;
      e_utxs  = 0;
      if (act) begin
        if (answered) begin
          if (uart_tx_ready) begin
            e_utxs = 1;
            act    = 0;
          end
        end else begin
          // age 0: CS setup edge, age 1: start pulse edge, ages 2..TO_CYC+1: response window
          if (age == 0) e_start = 1;
          else if (age >= 2) begin
            if (spi_rx_valid) begin
              answered = 1;
              e_utxd   = spi_rx_data;
              e_cs     = 1;
            end else if (age == TO_CYC + 1) begin
              act  = 0;
              e_cs = 1;
              e_to = 1;
            end
          end
          age++;
        end
      end else if (q.size() != 0) begin
        e_txd    = q.pop_front();
        e_cs     = 0;
        act      = 1;
        answered = 0;
        age      = 0;
      end
      if (uart_rx_valid) begin
        if (m_full) e_ovf = 1;
        else q.push_back(uart_rx_data);
      end
      e_cnt = (AW + 1)'(q.size());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_spi_cs_bar", 32'(spi_cs_bar), 32'(e_cs));
      chk("m_spi_start", 32'(spi_start), 32'(e_start));
      chk("m_spi_tx_data", 32'(spi_tx_data), 32'(e_txd));
      chk("m_uart_tx_data", 32'(uart_tx_data), 32'(e_utxd));
      chk("m_uart_tx_start", 32'(uart_tx_start), 32'(e_utxs));
      chk("m_fifo_count", 32'(fifo_count), 32'(e_cnt));
      chk("m_overflow", 32'(overflow), 32'(e_ovf));
      chk("m_timeout", 32'(timeout), 32'(e_to));
    end
  end

  task automatic push_byte(input logic [DW-1:0] d);
    uart_rx_data  = d;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (spi_start === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_cs_high(input string name, output int unsigned waited);
    bit ok = 0;
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      if (spi_cs_bar === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] bexp [4];
    int unsigned   start_cyc, waited;
    bexp = '{8'h01, 8'h02, 8'h03, 8'h04};

    reset = 1'b1; uart_rx_data = '0; uart_rx_valid = 1'b0;
    spi_rx_data = '0; spi_rx_valid = 1'b0; uart_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(spi_cs_bar), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte: latency and response path
    push_byte(8'hA5);
    chk("single_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("single_cs_low", 32'(spi_cs_bar), 32'd0);
    chk("single_no_early_start", 32'(spi_start), 32'd0);
    @(negedge clk);
    chk("single_start", 32'(spi_start), 32'd1);
    chk("single_txd", 32'(spi_tx_data), 32'hA5);
    @(negedge clk);
    chk("single_start_once", 32'(spi_start), 32'd0);
    spi_rx_data = 8'h3C; spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    chk("single_cs_high_first", 32'(spi_cs_bar), 32'd1);
    chk("single_no_tx_yet", 32'(uart_tx_start), 32'd0);
    @(negedge clk);
    chk("single_tx_start", 32'(uart_tx_start), 32'd1);
    chk("single_tx_data", 32'(uart_tx_data), 32'h3C);
    @(negedge clk);
    chk("single_tx_once", 32'(uart_tx_start), 32'd0);

    // Burst with overflow; every transfer times out
    push_byte(8'h00);
    wait_start("burst_first_start");
    start_cyc = cyc;
    for (int i = 1; i <= 5; i++) begin
      uart_rx_data = DW'(i); uart_rx_valid = 1'b1;
      @(negedge clk);
    end
    uart_rx_valid = 1'b0;
    chk("burst_count_full", 32'(fifo_count), 32'd4);
    chk("burst_overflow", 32'(overflow), 32'd1);
    wait_cs_high("burst_first_abort", waited);
    chk("timeout_latency", cyc - start_cyc, TO_CYC + 1);
    chk("timeout_flag", 32'(timeout), 32'd1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      wait_start("burst_start");
      chk("burst_order", 32'(spi_tx_data), 32'(bexp[j]));
    end
    @(negedge clk);
    wait_cs_high("burst_last_abort", waited);
    repeat (30) @(negedge clk);
    chk("burst_drained", 32'(fifo_count), 32'd0);
    chk("burst_no_fifth", 32'(spi_tx_data), 32'h04);

    // Backpressure on the UART side
    uart_tx_ready = 1'b0;
    push_byte(8'h5A);
    wait_start("bp_start");
    @(negedge clk);
    spi_rx_data = 8'hC3; spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    push_byte(8'h77);
    repeat (50) @(negedge clk);
    chk("bp_cs_held", 32'(spi_cs_bar), 32'd1);
    chk("bp_count", 32'(fifo_count), 32'd1);
    uart_tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_tx_start", 32'(uart_tx_start), 32'd1);
    chk("bp_tx_data", 32'(uart_tx_data), 32'hC3);
    chk("bp_cs_gap", 32'(spi_cs_bar), 32'd1);
    @(negedge clk);
    chk("bp_next_frame", 32'(spi_cs_bar), 32'd0);
    chk("bp_tx_once", 32'(uart_tx_start), 32'd0);
    repeat (30) @(negedge clk);

    // Reset in the middle of WAIT
    push_byte(8'h11);
    wait_start("rst_mid_start");
    @(negedge clk);
    push_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_cs", 32'(spi_cs_bar), 32'd1);
    chk("rstmid_count", 32'(fifo_count), 32'd0);
    chk("rstmid_ovf", 32'(overflow), 32'd0);
    chk("rstmid_to", 32'(timeout), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rstmid_no_start", 32'({spi_start, uart_tx_start}), 32'd0);
    end

    // Randomized traffic, including occasional resets
    for (int c = 0; c < 3000; c++) begin
      uart_rx_valid = ($urandom_range(0, 99) < 35);
      uart_rx_data  = DW'($urandom);
      spi_rx_valid  = ($urandom_range(0, 99) < 12);
      spi_rx_data   = DW'($urandom);
      uart_tx_ready = ($urandom_range(0, 99) < 60);
      reset         = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    uart_rx_valid = 1'b0; spi_rx_valid = 1'b0; uart_tx_ready = 1'b1; reset = 1'b0;
    repeat (100) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
